// File: rtl/fpu_result_collector.sv
// fpu_result_collector: issue/return controller around a fixed-latency FP32 add/sub datapath.
// Ports: in_* operation request (valid/ready, a, b, op, tag); add_* adder operand/result
// interface; out_* result FIFO head (valid/ready, r, tag, flags={sign,nan,inf,zero,subnormal}).
// Optional FPU_STICKY_FLAGS_EN adds sticky_clr / sticky_flags={nan,inf,subnormal}.
module fpu_result_collector #(
  parameter int WIDTH = 32,
  parameter int EXP_BITS = 8,
  parameter int MANT_BITS = 23,
  parameter int LATENCY = 6,
  parameter int TAG_W = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic arst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic add_op,
  input  logic [WIDTH-1:0] add_r,
  output logic out_valid,
  input  logic out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0] out_flags
`ifdef FPU_STICKY_FLAGS_EN
  ,
  input  logic sticky_clr,
  output logic [2:0] sticky_flags
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = WIDTH + TAG_W + 5;
  logic fire, push, pop;
  logic [LATENCY-1:0] vld;
  logic [TAG_W-1:0] tags [LATENCY];
  logic [CW-1:0] credits, fifo_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EXP_BITS-1:0] e;
  logic [MANT_BITS-1:0] m;
  logic [4:0] flags;
  // credits counts ops in flight plus entries queued, so an accepted op always has a slot
  assign in_ready = credits < CW'(FIFO_DEPTH);
  assign fire = in_valid & in_ready;
  assign add_a = fire ? in_a : '0;
  assign add_b = fire ? in_b : '0;
  assign add_op = fire & in_op;
  assign e = add_r[WIDTH-2 -: EXP_BITS];
  assign m = add_r[MANT_BITS-1:0];
  assign flags = {add_r[WIDTH-1], &e & |m, &e & ~|m, ~|e & ~|m, ~|e & |m};
  assign push = vld[LATENCY-1];
  assign out_valid = fifo_cnt != '0;
  assign pop = out_valid & out_ready;
  assign {out_r, out_tag, out_flags} = out_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld <= '0;
      credits <= '0;
      fifo_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      vld <= {vld[LATENCY-2:0], fire};
      credits <= credits + CW'(fire) - CW'(pop);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
    end
  end
  // tags and storage need no reset: they are only observed behind a valid
  always_ff @(posedge clk) begin
    tags[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++) tags[i] <= tags[i-1];
    if (push) mem[wr_ptr] <= {add_r, tags[LATENCY-1], flags};
  end
`ifdef FPU_STICKY_FLAGS_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) sticky_flags <= '0;
    else sticky_flags <= (sticky_clr ? 3'b000 : sticky_flags) | (push ? {flags[3], flags[2], flags[0]} : 3'b000);
  end
`endif
endmodule

// File: tb/tb_fpu_result_collector.sv
// tb_fpu_result_collector: scoreboard bench with a behavioural 6-stage adder stand-in.
module tb_fpu_result_collector;
  logic clk = 0, arst_n = 0, in_valid = 0, in_op = 0, add_op, out_valid, out_ready = 0, in_ready;
  logic [31:0] in_a = 0, in_b = 0, add_a, add_b, add_r, out_r;
  logic [3:0] in_tag = 0, out_tag;
  logic [4:0] out_flags;
  logic [31:0] pipe [6];
  logic [40:0] q [$];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  fpu_result_collector dut (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_tag(in_tag), .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_r(add_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag), .out_flags(out_flags)
  );
  function automatic logic [31:0] fake_add(logic [31:0] a, logic [31:0] b, logic op);
    if (a == 32'h3F800000 && b == 32'h40000000 && !op) return 32'h40400000;
    if (a == 32'h7F800001 && b == 32'h3F800000 && !op) return 32'h7FC00000;
    if (a == 32'h3F800000 && b == 32'h3F800000 && op) return 32'h00000000;
    return a ^ b ^ {op, 31'b0};
  endfunction
  function automatic logic [4:0] fl(logic [31:0] r);
    logic [7:0] e;
    logic [22:0] m;
    e = r[30:23];
    m = r[22:0];
    return {r[31], e == 8'hFF && m != 0, e == 8'hFF && m == 0, e == 0 && m == 0, e == 0 && m != 0};
  endfunction
  always @(posedge clk) begin
    pipe[0] <= fake_add(add_a, add_b, add_op);
    for (int i = 1; i < 6; i++) pipe[i] <= pipe[i-1];
  end
  assign add_r = pipe[5];
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (arst_n) begin
      if (q.size() == 0) chk("empty_no_valid", 64'(out_valid), 64'd0);
      else if (out_valid && out_ready) chk("result_order", 64'({out_r, out_tag, out_flags}), 64'(q.pop_front()));
      if (in_valid && in_ready) begin
        logic [31:0] r;
        r = fake_add(in_a, in_b, in_op);
        q.push_back({r, in_tag, fl(r)});
        chk("credit_bound", 64'(q.size() <= 8), 64'd1);
      end
    end
  end
  task automatic issue(logic [31:0] a, logic [31:0] b, logic op, logic [3:0] tag);
    int t;
    in_a = a;
    in_b = b;
    in_op = op;
    in_tag = tag;
    in_valid = 1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 50);
    if (t >= 50) chk("issue_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic expect_out(string tag, logic [31:0] r, logic [4:0] f);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 30);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_r"}, 64'(out_r), 64'(r));
    chk({tag, "_flags"}, 64'(out_flags), 64'(f));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [3:0] tag;
    logic f;
    int acc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 arst_n = 1;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_out_r", 64'({out_r, out_tag, out_flags}), 64'd0);
    @(posedge clk);
    #1 out_ready = 1;
    in_a = 32'h3F800000;
    in_b = 32'h40000000;
    in_op = 0;
    in_tag = 3;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_r", 64'(out_r), 64'h40400000);
    chk("lat_tag", 64'(out_tag), 64'd3);
    chk("lat_flags", 64'(out_flags), 64'd0);
    @(negedge clk);
    chk("lat_popped", 64'(out_valid), 64'd0);
    issue(32'h7F800001, 32'h3F800000, 0, 5);
    expect_out("nan", 32'h7FC00000, 5'b01000);
    issue(32'h3F800000, 32'h3F800000, 1, 6);
    expect_out("zero", 32'h00000000, 5'b00010);
    issue(32'h7F800000, 32'h0, 0, 7);
    expect_out("inf", 32'h7F800000, 5'b00100);
    issue(32'h00000001, 32'h0, 0, 8);
    expect_out("sub", 32'h00000001, 5'b00001);
    issue(32'h80000000, 32'h0, 0, 9);
    expect_out("negz", 32'h80000000, 5'b10010);
    repeat (3) @(posedge clk);
    #1 out_ready = 0;
    in_valid = 1;
    tag = 0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      in_a = $urandom;
      in_b = $urandom;
      in_tag = tag;
      @(negedge clk);
      f = in_ready;
      @(posedge clk);
      #1;
      if (f) begin
        acc++;
        tag++;
      end
    end
    in_valid = 0;
    chk("full_accepted", 64'(acc), 64'd8);
    @(negedge clk);
    chk("full_not_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1 out_ready = 1;
    @(negedge clk);
    chk("pre_pop_not_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("post_pop_ready", 64'(in_ready), 64'd1);
    repeat (10) @(posedge clk);
    chk("full_drained", 64'(q.size()), 64'd0);
    #1 out_ready = 0;
    issue(32'h1, 32'h2, 0, 1);
    issue(32'h3, 32'h4, 0, 2);
    repeat (8) @(posedge clk);
    issue(32'h5, 32'h6, 0, 3);
    issue(32'h7, 32'h8, 1, 4);
    issue(32'h9, 32'hA, 0, 5);
    @(posedge clk);
    #1 arst_n = 0;
    q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 arst_n = 1;
    @(negedge clk);
    chk("mid_rel_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rel_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rel_out", 64'({out_r, out_tag, out_flags}), 64'd0);
    @(posedge clk);
    #1 out_ready = 1;
    repeat (12) @(posedge clk);
    #1;
    issue(32'hC0000000, 32'h0, 0, 11);
    expect_out("after_rst", 32'hC0000000, 5'b10000);
    tag = 0;
    in_a = $urandom;
    in_b = $urandom;
    in_op = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) == 0);
      in_tag = tag;
      @(negedge clk);
      f = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (f) begin
        tag++;
        in_a = $urandom;
        in_b = $urandom;
        in_op = 1'($urandom_range(1));
      end
    end
    in_valid = 0;
    out_ready = 1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("final_drained", 64'(q.size()), 64'd0);
    chk("final_out_valid", 64'(out_valid), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fpu_result_collector.md
Name: fpu_result_collector

Overview:
- Issue/return controller wrapped around the fixed-latency FP32 add/sub datapath (add_sub_main).
- Accepts operations over a valid/ready handshake, drives the adder operand ports, and tracks each issued op through the adder pipeline with a tag.
- Captures each result with IEEE-754 class flags into an output FIFO drained by a valid/ready consumer.
- Credit-based issue guarantees the FIFO never overflows, even though the adder cannot be stalled.

Parameters:
- WIDTH, 32, operand/result width (FP32 only)
- EXP_BITS, 8, exponent field width
- MANT_BITS, 23, mantissa field width
- LATENCY, 6, cycles from operands on add_a/add_b/add_op to matching value on add_r
- TAG_W, 4, width of the user tag carried alongside each op
- FIFO_DEPTH, 8, output FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  operation accepted when in_valid & in_ready
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  1  0 = add, 1 = subtract (A-B)
- in_tag  in  TAG_W  user tag, returned with the result
- add_a  out  WIDTH  to adder a
- add_b  out  WIDTH  to adder b
- add_op  out  1  to adder operation_select
- add_r  in  WIDTH  from adder R
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_r  out  WIDTH  result word
- out_tag  out  TAG_W  tag of this result
- out_flags  out  5  {sign, nan, inf, zero, subnormal}

Behaviour:
- Issue: fire = in_valid & in_ready.
  - add_a/add_b/add_op are combinational pass-through of in_a/in_b/in_op when fire; otherwise driven to 0.
- Tracking:
  - LATENCY-deep shift register of {valid, tag}; entry 0 loads {fire, in_tag} each edge.
  - When the last stage is valid at an edge, {add_r, tag, flags(add_r)} is written into the FIFO.
- Credits:
  - credits_used = inflight_cnt + fifo_cnt, registered.
  - in_ready = (credits_used < FIFO_DEPTH); computed from registered counts only, with no same-cycle bypass from a pop.
  - Issue and pop in the same cycle: count unchanged.
  - Write-into-FIFO moves one credit from inflight to fifo and leaves the total unchanged.
- Latency: an op fired at edge k has its result written at edge k+LATENCY. out_valid is high after that edge if the FIFO was empty (LATENCY cycles issue-to-output).
- FIFO:
  - First-word-fall-through; out_r/out_tag/out_flags show the head entry.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle are both honoured, including when full (credits make push-when-full without pop impossible).
  - Push when empty with out_ready high: the data appears the next cycle. There is no combinational bypass.
  - Order is strictly the issue order.
- Flags, computed from add_r:
  - sign = bit 31.
  - nan = exp all ones & mant != 0.
  - inf = exp all ones & mant == 0.
  - zero = exp == 0 & mant == 0.
  - subnormal = exp == 0 & mant != 0.
  - Result bits are never modified.
- Reset, any time including mid-operation:
  - All tracking valids cleared; inflight_cnt and fifo_cnt = 0.
  - out_valid = 0; out_r, out_tag, out_flags = 0.
  - in_ready = 1 from the first cycle after reset release.
  - In-flight ops are discarded. Adder outputs arriving after reset are ignored because their tracking valids are 0.
- Pointers wrap modulo FIFO_DEPTH; fifo_cnt ranges 0..FIFO_DEPTH.

Optional Feature:
- FPU_STICKY_FLAGS_EN defined:
  - Adds ports sticky_clr (in, 1) and sticky_flags (out, 3) = {nan, inf, subnormal}.
  - Each bit is set when a FIFO write carries that flag.
  - Bits are cleared by sticky_clr; a set in the same cycle as sticky_clr wins.
  - Reset value 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Issue a=0x3F800000, b=0x40000000, op=0, tag=3 with out_ready=1 -> after 6 cycles out_valid=1, out_r=0x40400000, out_tag=3, out_flags=5'b00000; popped the following edge.
- a=0x7F800001, b=0x3F800000 -> out_r=0x7FC00000, out_flags nan=1, sign=0.
- a=0x3F800000, b=0x3F800000, op=1 -> out_r=0x00000000, zero=1.
- out_ready=0, continuous in_valid -> exactly 8 ops accepted, then in_ready=0. Raise out_ready -> 8 results in tag order 0..7; in_ready returns 1 the cycle after the first pop.
- Assert arst_n=0 with 3 ops in flight and 2 queued -> out_valid=0 and in_ready=1 after release; no stale result ever appears.
- Random back-pressure with issue and pop in the same cycle while credits_used=8 -> no loss, no duplication, no overflow; out_tag sequence equals in_tag sequence.
